tfhe_axil_cmd_master: RTL and testbench
=======================================

TFHE_AXIL_CMD_MASTER -- requirements
Module: tfhe_axil_cmd_master

Interface
REQ-001 SHALL have parameters: C_M_AXI_DATA_WIDTH, 32, AXI data width; C_M_AXI_ADDR_WIDTH, 6, AXI byte-address width; TIMEOUT_CYCLES, 1024, busy-cycle count that raises timeout_err.
REQ-002 SHALL have one clock and an asynchronous, active-high reset; ports M_AXI_ACLK and M_AXI_ARESET.
REQ-003 SHALL have ports (name direction width meaning):
 M_AXI_ACLK  in  1  clock
 M_AXI_ARESET  in  1  async active-high reset
 cmd_valid  in  1  command offered
 cmd_ready  out  1  command accepted when high with cmd_valid
 cmd_write  in  1  1 = write, 0 = read
 cmd_addr  in  ADDR_WIDTH  byte address
 cmd_wdata  in  DATA_WIDTH  write data
 cmd_wstrb  in  DATA_WIDTH/8  write strobes
 rsp_valid  out  1  response available
 rsp_ready  in  1  response consumed
 rsp_write  out  1  response belongs to a write
 rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
 rsp_resp  out  2  BRESP/RRESP as received
 rsp_latency  out  16  busy cycles of that transaction, saturating
 timeout_err  out  1  sticky timeout flag
 clear_err  in  1  clears timeout_err
 M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY  standard AXI4-Lite master directions and widths

Function
REQ-004 SHALL implement FSM states IDLE, WADDR, WRESP, RADDR, RDATA, RSP; one transaction outstanding at most.
REQ-005 cmd_ready SHALL be 1 only in IDLE (registered); acceptance edge moves IDLE->WADDR (cmd_write=1) or IDLE->RADDR (cmd_write=0) and latches addr/wdata/wstrb/write.
REQ-006 In WADDR: AWVALID and WVALID SHALL both rise the cycle after acceptance; each SHALL drop the cycle after its own handshake and never drop before it; AWADDR/WDATA/WSTRB stable while their VALID is high.
REQ-007 WADDR->WRESP SHALL occur once both AW and W handshakes have completed (same or different cycles); BREADY SHALL be 1 only in WRESP.
REQ-008 WRESP: on BVALID&&BREADY capture BRESP, rsp_rdata=0, go RSP.
REQ-009 RADDR: ARVALID rises the cycle after acceptance, held until ARREADY; on handshake go RDATA; RREADY SHALL be 1 only in RDATA.
REQ-010 RDATA: on RVALID&&RREADY capture RDATA/RRESP, go RSP.
REQ-011 RSP: rsp_valid=1 with rsp_* stable until rsp_valid&&rsp_ready, then IDLE; next command cannot be accepted in that same cycle.
REQ-012 AWPROT and ARPROT SHALL be constant 3'b000.
REQ-013 Busy counter SHALL clear on acceptance, increment each cycle in WADDR/WRESP/RADDR/RDATA, saturate at 0xFFFF; rsp_latency = counter value including the B/R handshake cycle (zero-wait slave write => 2, read => 2).
REQ-014 When counter equals TIMEOUT_CYCLES while busy, timeout_err SHALL set; transaction SHALL NOT abort and VALIDs SHALL stay asserted per AXI rules.
REQ-015 clear_err SHALL clear timeout_err next cycle; a set event in the same cycle wins.
REQ-016 SLVERR/DECERR SHALL be passed to rsp_resp unmodified, no retry.

Reset
REQ-017 M_AXI_ARESET high SHALL asynchronously force IDLE, and all VALID/READY outputs, cmd_ready, rsp_valid, rsp_*, counter, timeout_err to 0, including mid-transaction; cmd_ready rises on first clock edge after release.

Verification
REQ-018 Write 0x00/0x00000001/strb 0xF, slave zero-wait -> AWVALID=WVALID=1 one cycle after accept, one B, rsp_write=1, rsp_resp=00, rsp_latency=2.
REQ-019 Read 0x04, ARREADY delayed 3 cycles, RDATA=0xDEADBEEF -> ARVALID held 4 cycles, rsp_rdata=0xDEADBEEF, rsp_latency=5.
REQ-020 Write with AWREADY immediate, WREADY delayed 5 cycles -> AWVALID drops after 1 cycle, WVALID held 6 cycles, BREADY only after both.
REQ-021 TIMEOUT_CYCLES=16, slave never responds -> timeout_err=1 at 16th busy cycle, AWVALID still 1; clear_err pulse clears it, it does not re-set (counter past 16).
REQ-022 Reset asserted in RDATA -> RREADY/rsp_valid/cmd_ready 0 immediately; after release cmd_ready=1, next read completes normally.
REQ-023 Read returning RRESP=10 with rsp_ready low 4 cycles -> rsp_valid and rsp_resp=10 stable 4 cycles, cmd_ready=0 until consumed.

Source files
------------

// File: rtl/tfhe_axil_cmd_master.sv
// tfhe_axil_cmd_master
// Turns a simple valid/ready command port into single AXI4-Lite transactions,
// one outstanding at a time. It returns each response with its busy-cycle
// latency and raises a sticky flag when a transaction runs too long.
module tfhe_axil_cmd_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 6,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESET,
  // command side
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  // response side
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic                              rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic [15:0]                       rsp_latency,
  output logic                              timeout_err,
  input  logic                              clear_err,
  // AXI4-Lite write address / data / response
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  // AXI4-Lite read address / data
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4,
    RSP   = 3'd5
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_q;
  logic [15:0]                     busy_cnt;
  logic [15:0]                     busy_cnt_inc;

  logic accept;
  logic busy;
  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic b_hs;
  logic r_hs;
  logic aw_done;
  logic w_done;
  logic timeout_hit;

  assign accept = cmd_valid && cmd_ready;
  assign busy   = (state == WADDR) || (state == WRESP) ||
                  (state == RADDR) || (state == RDATA);

  assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;
  assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
  // B/R handshakes are decoded from state so they do not loop through the
  // READY outputs produced by the next-state logic below.
  assign b_hs  = (state == WRESP) && M_AXI_BVALID;
  assign r_hs  = (state == RDATA) && M_AXI_RVALID;

  // A channel is finished once its VALID has dropped or is handshaking now.
  assign aw_done = !M_AXI_AWVALID || M_AXI_AWREADY;
  assign w_done  = !M_AXI_WVALID || M_AXI_WREADY;

  // Count including the current busy cycle, saturating at 0xFFFF.
  assign busy_cnt_inc = (busy_cnt == 16'hFFFF) ? busy_cnt : busy_cnt + 16'd1;

  // The flag is set on the edge where the counter reaches TIMEOUT_CYCLES.
  // The counter only climbs, so this fires once per transaction.
  assign timeout_hit = busy && (busy_cnt != 16'hFFFF) &&
                       ((int'(busy_cnt) + 1) == TIMEOUT_CYCLES);

  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_WSTRB  = wstrb_q;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) state <= IDLE;
    else              state <= state_nxt;
  end

  // Next-state decode plus the state-derived READY/VALID outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    state_nxt    = state;
    M_AXI_BREADY = 1'b0;
    M_AXI_RREADY = 1'b0;
    rsp_valid    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = cmd_write ? WADDR : RADDR;
      end
      WADDR: begin
        if (aw_done && w_done) state_nxt = WRESP;
      end
      WRESP: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) state_nxt = RSP;
      end
      RADDR: begin
        if (ar_hs) state_nxt = RDATA;
      end
      RDATA: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) state_nxt = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // cmd_ready is registered: high exactly while the machine sits in IDLE,
  // and it first rises on the first clock edge after reset is released.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) cmd_ready <= 1'b0;
    else              cmd_ready <= (state_nxt == IDLE);
  end

  // Latch the command on acceptance; it drives the AXI payload until the next one.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    // NOTE: these are plain flops, not a memory array, so they take the async reset like all other state.
    if (M_AXI_ARESET) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (accept) begin
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
      wstrb_q <= cmd_wstrb;
    end
  end

  // AXI VALIDs rise the cycle after acceptance and each drops after its own handshake.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
    end else if (accept) begin
      M_AXI_AWVALID <= cmd_write;
      M_AXI_WVALID  <= cmd_write;
      M_AXI_ARVALID <= !cmd_write;
    end else begin
      if (aw_hs) M_AXI_AWVALID <= 1'b0;
      if (w_hs)  M_AXI_WVALID  <= 1'b0;
      if (ar_hs) M_AXI_ARVALID <= 1'b0;
    end
  end

  // Busy-cycle counter: cleared on acceptance, counts while a transaction is in flight.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET)  busy_cnt <= '0;
    else if (accept)   busy_cnt <= '0;
    else if (busy)     busy_cnt <= busy_cnt_inc;
  end

  // Response capture on the B or R handshake; the latency includes that cycle.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= 2'b00;
      rsp_latency <= '0;
    end else if (b_hs) begin
      rsp_write   <= 1'b1;
      rsp_rdata   <= '0;
      rsp_resp    <= M_AXI_BRESP;
      rsp_latency <= busy_cnt_inc;
    end else if (r_hs) begin
      rsp_write   <= 1'b0;
      rsp_rdata   <= M_AXI_RDATA;
      rsp_resp    <= M_AXI_RRESP;
      rsp_latency <= busy_cnt_inc;
    end
  end

  // Sticky timeout flag; a new timeout wins over a simultaneous clear.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET)     timeout_err <= 1'b0;
    else if (timeout_hit) timeout_err <= 1'b1;
    else if (clear_err)   timeout_err <= 1'b0;
  end

endmodule

// File: tb/tb_tfhe_axil_cmd_master.sv
// tb_tfhe_axil_cmd_master
// Directed bench: a table of transactions served by a delay-programmable
// slave, plus hand-written sequences for timeout and mid-transaction reset.
module tb_tfhe_axil_cmd_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [5:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] rsp_latency;
  logic        timeout_err;
  logic        clear_err = 1'b0;
  logic [5:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = '0;
  logic        bvalid = 1'b0;
  logic        bready;
  logic [5:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;
  logic        rready;

  int checks = 0;
  int errors = 0;

  tfhe_axil_cmd_master #(
    .C_M_AXI_DATA_WIDTH(32),
    .C_M_AXI_ADDR_WIDTH(6),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .M_AXI_ACLK(clk),
    .M_AXI_ARESET(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp),
    .rsp_latency(rsp_latency),
    .timeout_err(timeout_err),
    .clear_err(clear_err),
    .M_AXI_AWADDR(awaddr),
    .M_AXI_AWPROT(awprot),
    .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata),
    .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp),
    .M_AXI_BVALID(bvalid),
    .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr),
    .M_AXI_ARPROT(arprot),
    .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata),
    .M_AXI_RRESP(rresp),
    .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  always #5 clk = ~clk;

  // One transaction: command fields, slave behaviour, expected results.
  typedef struct {
    logic        write;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_dly;     // cycles AWREADY is held low
    int          w_dly;      // cycles WREADY is held low
    int          ar_dly;     // cycles ARREADY is held low
    int          rsp_dly;    // cycles rsp_ready is held low once rsp_valid rises
    logic [31:0] sl_rdata;   // data the slave returns on R
    logic [1:0]  sl_resp;    // BRESP/RRESP the slave returns
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    int          exp_lat;
    int          exp_aw;     // cycles AWVALID is seen high
    int          exp_w;      // cycles WVALID is seen high
    int          exp_ar;     // cycles ARVALID is seen high
  } txn_t;

  txn_t vec [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic slave_idle();
    awready = 1'b0;
    wready  = 1'b0;
    arready = 1'b0;
    bvalid  = 1'b0;
    rvalid  = 1'b0;
    bresp   = 2'b00;
    rresp   = 2'b00;
    rdata   = '0;
  endtask

  // Drive one command and act as the AXI slave; everything is sampled and
  // driven on the falling edge, so handshakes happen on the next rising edge.
  task automatic run_txn(input txn_t t);
    int k;
    int aw_hi;
    int w_hi;
    int ar_hi;
    bit aw_seen;
    bit w_seen;
    bit ar_seen;
    bit resp_done;
    bit bready_early;
    bit rready_early;
    bit payload_moved;
    k = 1; aw_hi = 0; w_hi = 0; ar_hi = 0;
    aw_seen = 0; w_seen = 0; ar_seen = 0; resp_done = 0;
    bready_early = 0; rready_early = 0; payload_moved = 0;

    @(negedge clk);
    check("cmd_ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = t.write;
    cmd_addr  = t.addr;
    cmd_wdata = t.wdata;
    cmd_wstrb = t.wstrb;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_wdata = 32'hFFFF_FFFF;
    cmd_addr  = 6'h3F;
    cmd_wstrb = 4'h0;
    check("cmd_ready_after_accept", cmd_ready, 0);
    if (t.write) begin
      check("awvalid_first_cycle", awvalid, 1);
      check("wvalid_first_cycle", wvalid, 1);
    end else begin
      check("arvalid_first_cycle", arvalid, 1);
    end

    while (rsp_valid !== 1'b1 && k < 100) begin
      if (awvalid) aw_hi++;
      if (wvalid)  w_hi++;
      if (arvalid) ar_hi++;
      if (awvalid && awaddr !== t.addr) payload_moved = 1;
      if (wvalid && (wdata !== t.wdata || wstrb !== t.wstrb)) payload_moved = 1;
      if (arvalid && araddr !== t.addr) payload_moved = 1;
      if (bready && !(aw_seen && w_seen)) bready_early = 1;
      if (rready && !ar_seen) rready_early = 1;
      awready = (k > t.aw_dly);
      wready  = (k > t.w_dly);
      arready = (k > t.ar_dly);
      bvalid  = aw_seen && w_seen && !resp_done;
      bresp   = t.sl_resp;
      rvalid  = ar_seen && !resp_done;
      rdata   = t.sl_rdata;
      rresp   = t.sl_resp;
      if (awvalid && awready) aw_seen = 1;
      if (wvalid && wready)   w_seen = 1;
      if (arvalid && arready) ar_seen = 1;
      if ((bvalid && bready) || (rvalid && rready)) resp_done = 1;
      @(negedge clk);
      k++;
    end
    slave_idle();
    if (k >= 100) check("txn_completes_in_budget", 0, 1);

    for (int i = 0; i < t.rsp_dly; i++) begin
      check("rsp_valid_held", rsp_valid, 1);
      check("rsp_resp_held", rsp_resp, t.exp_resp);
      check("cmd_ready_low_in_rsp", cmd_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    check("rsp_valid", rsp_valid, 1);
    check("rsp_write", rsp_write, t.write);
    check("rsp_rdata", rsp_rdata, t.exp_rdata);
    check("rsp_resp", rsp_resp, t.exp_resp);
    check("rsp_latency", rsp_latency, t.exp_lat);
    check("cmd_ready_in_rsp", cmd_ready, 0);
    check("awvalid_cycles", aw_hi, t.exp_aw);
    check("wvalid_cycles", w_hi, t.exp_w);
    check("arvalid_cycles", ar_hi, t.exp_ar);
    check("bready_only_after_aw_w", bready_early, 0);
    check("rready_only_after_ar", rready_early, 0);
    check("payload_stable", payload_moved, 0);
    check("timeout_quiet", timeout_err, 0);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_drops", rsp_valid, 0);
  endtask

  initial begin
    // write, addr, wdata, strb, aw_dly, w_dly, ar_dly, rsp_dly,
    // sl_rdata, sl_resp, exp_rdata, exp_resp, exp_lat, exp_aw, exp_w, exp_ar
    // Zero-wait write: AW+W in busy cycle 1, B in cycle 2.
    vec[0] = '{1'b1, 6'h00, 32'h0000_0001, 4'hF, 0, 0, 0, 0,
               32'h0, 2'b00, 32'h0, 2'b00, 2, 1, 1, 0};
    // Read, ARREADY low 3 cycles: AR in cycle 4, R in cycle 5.
    vec[1] = '{1'b0, 6'h04, 32'h0, 4'h0, 0, 0, 3, 0,
               32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 2'b00, 5, 0, 0, 4};
    // Write, AW immediate, WREADY low 5 cycles: W in cycle 6, B in cycle 7.
    vec[2] = '{1'b1, 6'h08, 32'hA5A5_0F0F, 4'h3, 0, 5, 0, 0,
               32'h0, 2'b00, 32'h0, 2'b00, 7, 1, 6, 0};
    // Read returning SLVERR, consumer stalls 4 cycles.
    vec[3] = '{1'b0, 6'h10, 32'h0, 4'h0, 0, 0, 0, 4,
               32'h1234_5678, 2'b10, 32'h1234_5678, 2'b10, 2, 0, 0, 1};
    // Write, AWREADY low 2 cycles, DECERR: AW in cycle 3, B in cycle 4.
    vec[4] = '{1'b1, 6'h3C, 32'hCAFE_F00D, 4'h8, 2, 0, 0, 1,
               32'h0, 2'b11, 32'h0, 2'b11, 4, 3, 1, 0};
    // Read, ARREADY low 1 cycle, EXOKAY passed through.
    vec[5] = '{1'b0, 6'h20, 32'h0, 4'h0, 0, 0, 1, 0,
               32'h0BAD_F00D, 2'b01, 32'h0BAD_F00D, 2'b01, 3, 0, 0, 2};

    // Reset state, then cmd_ready rising on the first edge after release.
    #12;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_rready", rready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_latency", rsp_latency, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("awprot_zero", awprot, 0);
    check("arprot_zero", arprot, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("cmd_ready_before_first_edge", cmd_ready, 0);
    @(negedge clk);
    check("cmd_ready_after_first_edge", cmd_ready, 1);

    for (int i = 0; i < 6; i++) run_txn(vec[i]);

    // Timeout: slave never answers a write; the flag appears once 16 busy
    // cycles have been counted, the transfer keeps waiting.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 6'h2C;
    cmd_wdata = 32'h5555_AAAA;
    cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 1; k < 16; k++) @(negedge clk);
    check("timeout_not_yet_at_15", timeout_err, 0);
    @(negedge clk);
    check("timeout_after_16", timeout_err, 1);
    check("awvalid_held_in_timeout", awvalid, 1);
    check("wvalid_held_in_timeout", wvalid, 1);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check("timeout_cleared", timeout_err, 0);
    repeat (5) @(negedge clk);
    check("timeout_not_reset_past_16", timeout_err, 0);
    check("awvalid_still_held", awvalid, 1);
    check("no_rsp_while_stalled", rsp_valid, 0);

    // Asynchronous reset while stuck in the write address phase.
    #2 rst = 1'b1;
    #1;
    check("async_rst_awvalid", awvalid, 0);
    check("async_rst_wvalid", wvalid, 0);
    check("async_rst_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_rst1", cmd_ready, 1);

    // Reset landing in RDATA: RREADY and friends drop at once.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 6'h18;
    @(negedge clk);
    cmd_valid = 1'b0;
    arready   = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    check("in_rdata_rready", rready, 1);
    #2 rst = 1'b1;
    #1;
    check("rdata_rst_rready", rready, 0);
    check("rdata_rst_rsp_valid", rsp_valid, 0);
    check("rdata_rst_cmd_ready", cmd_ready, 0);
    check("rdata_rst_arvalid", arvalid, 0);
    @(negedge clk);
    rst = 1'b0;
    run_txn(vec[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
